// File: rtl/roe_regfile.sv
// roe_regfile -- banked 16 x DW register file for the R.O.E core.
//
// Addresses are {bank[1:0], index[1:0]} as produced by the play-area
// register decoder. Two asynchronous read ports, one write port with a
// single write-back stage, and a sequenced clear of one 4-register bank.
//
// Optional feature macro: ROE_REGFILE_BYPASS_EN
//   defined   : reads of the pending write address return the pending data
//               (or 0 if the clear sequence hits that address on the next edge)
//   undefined : reads come only from the array
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   raddr_a / rdata_a   read port A (combinational)
//   raddr_b / rdata_b   read port B (combinational)
//   wen, waddr, wdata   write request, captured then committed one edge later
//   clr_req, clr_bank   start clearing bank clr_bank (ignored while clearing)
//   clr_busy            high while the four bank registers are being cleared
//   clr_done            one-cycle pulse after the last register is cleared

module roe_regfile #(
  parameter int DW   = 8,
  parameter int NREG = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [3:0]    raddr_b,
  output logic [DW-1:0] rdata_b,
  input  logic          wen,
  input  logic [3:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic          clr_req,
  input  logic [1:0]    clr_bank,
  output logic          clr_busy,
  output logic          clr_done
);

  localparam int NRD = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    DONE = 2'd2
  } clr_state_e;

  logic [NREG-1:0][DW-1:0] mem;

  // write-back stage
  logic          pend_v;
  logic [3:0]    pend_addr;
  logic [DW-1:0] pend_data;
  logic          wr_accept;

  // clear sequencer
  clr_state_e state, state_nxt;
  logic [1:0] bank;
  logic [1:0] idx;
  logic [3:0] clr_addr;

  assign clr_addr  = {bank, idx};
  assign wr_accept = wen && !clr_busy;

  // ---------------- clear FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    case (state)
      IDLE: if (clr_req) state_nxt = CLR;
      CLR: begin
        clr_busy = 1'b1;
        if (idx == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        clr_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank <= '0;
      idx  <= '0;
    end else if (state == IDLE && clr_req) begin
      bank <= clr_bank;
      idx  <= '0;
    end else if (state == CLR) begin
      idx  <= idx + 2'd1;
    end
  end

  // ---------------- write-back stage ----------------
  // pend_v tracks wen every cycle so back-to-back writes stream at 1/cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v    <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else begin
      pend_v <= wr_accept;
      if (wr_accept) begin
        pend_addr <= waddr;
        pend_data <= wdata;
      end
    end
  end

  // ---------------- array ----------------
  // The clear write is issued after the commit so it wins on an address clash.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '0;
    end else begin
      if (pend_v)   mem[pend_addr] <= pend_data;
      if (clr_busy) mem[clr_addr]  <= '0;
    end
  end

  // ---------------- read ports ----------------
  logic [NRD-1:0][3:0]    raddr;
  logic [NRD-1:0][DW-1:0] rdata;

  assign raddr   = {raddr_b, raddr_a};
  assign rdata_a = rdata[0];
  assign rdata_b = rdata[1];

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    always_comb begin
      rdata[p] = mem[raddr[p]];
`ifdef ROE_REGFILE_BYPASS_EN
      // Forward the in-flight write, but a clear landing on the same
      // address at the next edge overrides it.
      if (pend_v && raddr[p] == pend_addr) begin
        if (clr_busy && raddr[p] == clr_addr) rdata[p] = '0;
        else                                  rdata[p] = pend_data;
      end
`endif
    end
  end

endmodule
